// File: rtl/axi_pkg.sv
// Shared AXI4 types and burst helpers for the slave front-end blocks.
package axi_pkg;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED    = 2'b00,
    AXI_BURST_INCR     = 2'b01,
    AXI_BURST_WRAP     = 2'b10,
    AXI_BURST_RESERVED = 2'b11
  } axi_burst_t;

  typedef enum logic [2:0] {
    AXI_SIZE_1B   = 3'd0,
    AXI_SIZE_2B   = 3'd1,
    AXI_SIZE_4B   = 3'd2,
    AXI_SIZE_8B   = 3'd3,
    AXI_SIZE_16B  = 3'd4,
    AXI_SIZE_32B  = 3'd5,
    AXI_SIZE_64B  = 3'd6,
    AXI_SIZE_128B = 3'd7
  } axi_size_t;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'b00,
    AXI_RESP_EXOKAY = 2'b01,
    AXI_RESP_SLVERR = 2'b10,
    AXI_RESP_DECERR = 2'b11
  } axi_resp_t;

  // Addresses are 4 KB pages; an INCR burst may not leave its page.
  localparam int unsigned AXI_4KB_SHIFT = 12;

  // Helpers work on a wide address; callers truncate to their own width.
  localparam int unsigned AXI_MAX_ADDR_W = 64;
  typedef logic [AXI_MAX_ADDR_W-1:0] axi_addr_t;

  // Bytes transferred per beat for a given size code.
  function automatic axi_addr_t get_bytes_from_size(axi_size_t size);
    return 64'd1 << size;
  endfunction

  // Lower bound of the wrap window: start address aligned to the burst span.
  function automatic axi_addr_t wrap_lower(axi_addr_t addr, axi_size_t size, logic [31:0] len);
    axi_addr_t span;
    span = get_bytes_from_size(size) * ({32'd0, len} + 64'd1);
    return addr & ~(span - 64'd1);
  endfunction

  // Classify a descriptor: SLVERR for anything the datapath must not honour.
  function automatic axi_resp_t burst_legal(axi_burst_t burst, axi_size_t size, logic [31:0] len,
                                            axi_addr_t addr, logic [31:0] data_width);
    axi_addr_t bytes;
    axi_addr_t start;
    axi_addr_t last;
    logic      bad_burst;
    logic      bad_size;
    logic      bad_wrap_len;
    logic      bad_wrap_align;
    logic      bad_4kb;
    bytes          = get_bytes_from_size(size);
    start          = addr & ~(bytes - 64'd1);
    last           = start + bytes * ({32'd0, len} + 64'd1) - 64'd1;
    bad_burst      = (burst == AXI_BURST_RESERVED);
    bad_size       = (bytes > {32'd0, data_width >> 3});
    bad_wrap_len   = (burst == AXI_BURST_WRAP) &&
                     !((len == 32'd1) || (len == 32'd3) || (len == 32'd7) || (len == 32'd15));
    bad_wrap_align = (burst == AXI_BURST_WRAP) && ((addr & (bytes - 64'd1)) != 64'd0);
    bad_4kb        = (burst == AXI_BURST_INCR) &&
                     ((start >> AXI_4KB_SHIFT) != (last >> AXI_4KB_SHIFT));
    if (bad_burst || bad_size || bad_wrap_len || bad_wrap_align || bad_4kb) begin
      return AXI_RESP_SLVERR;
    end else begin
      return AXI_RESP_OKAY;
    end
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Per-beat address generator: takes one AXI4 burst descriptor and emits one
// address per data beat with index, last flag, ID and response code.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 8,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [2:0]            cmd_size,
  input  logic [1:0]            cmd_burst,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  output logic                  beat_valid,
  input  logic                  beat_ready,
  output logic [ADDR_WIDTH-1:0] beat_addr,
  output logic [LEN_WIDTH-1:0]  beat_idx,
  output logic                  beat_last,
  output logic [ID_WIDTH-1:0]   beat_id,
  output logic [1:0]            beat_resp
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);

  state_t                state_q;
  logic                  cmd_ready_q;
  logic                  beat_valid_q;
  logic                  beat_last_q;
  logic [ADDR_WIDTH-1:0] beat_addr_q;
  logic [LEN_WIDTH-1:0]  beat_idx_q;
  logic [ID_WIDTH-1:0]   beat_id_q;
  axi_resp_t             beat_resp_q;
  logic [LEN_WIDTH-1:0]  len_q;
  axi_size_t             size_q;
  axi_burst_t            burst_q;
  logic [ADDR_WIDTH-1:0] wrap_lower_q;
  logic [ADDR_WIDTH-1:0] wrap_end_q;

  axi_resp_t             cmd_resp_d;
  axi_burst_t            cmd_burst_d;
  logic [ADDR_WIDTH-1:0] cmd_lower_d;
  logic [ADDR_WIDTH-1:0] cmd_end_d;
  logic [ADDR_WIDTH-1:0] bytes_d;
  logic [ADDR_WIDTH-1:0] incr_d;
  logic [ADDR_WIDTH-1:0] next_addr_d;
  logic [LEN_WIDTH-1:0]  next_idx_d;

  // Descriptor decode: legality, effective burst type and wrap window bounds.
  always_comb begin
    cmd_resp_d  = burst_legal(axi_burst_t'(cmd_burst), axi_size_t'(cmd_size), 32'(cmd_len),
                              axi_addr_t'(cmd_addr), 32'(DATA_WIDTH));
    cmd_lower_d = ADDR_WIDTH'(wrap_lower(axi_addr_t'(cmd_addr), axi_size_t'(cmd_size), 32'(cmd_len)));
    cmd_end_d   = cmd_lower_d + ADDR_WIDTH'(get_bytes_from_size(axi_size_t'(cmd_size)) *
                                            (axi_addr_t'(cmd_len) + 64'd1));
    // Illegal bursts replay the start address so the data still drains.
    if (cmd_resp_d == AXI_RESP_OKAY) begin
      cmd_burst_d = axi_burst_t'(cmd_burst);
    end else begin
      cmd_burst_d = AXI_BURST_FIXED;
    end
  end

  // Next-beat address and index for the burst in progress.
  always_comb begin
    bytes_d     = ADDR_WIDTH'(get_bytes_from_size(size_q));
    incr_d      = beat_addr_q + bytes_d;
    next_idx_d  = beat_idx_q + LEN_ONE;
    next_addr_d = beat_addr_q;
    case (burst_q)
      AXI_BURST_FIXED: next_addr_d = beat_addr_q;
      AXI_BURST_INCR:  next_addr_d = (beat_addr_q & ~(bytes_d - ADDR_ONE)) + bytes_d;
      AXI_BURST_WRAP: begin
        if (incr_d == wrap_end_q) begin
          next_addr_d = wrap_lower_q;
        end else begin
          next_addr_d = incr_d;
        end
      end
      default:         next_addr_d = beat_addr_q;
    endcase
  end

  // Burst FSM: accept a descriptor in IDLE, then step one beat per handshake.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q      <= ST_IDLE;
      cmd_ready_q  <= 1'b0;
      beat_valid_q <= 1'b0;
      beat_last_q  <= 1'b0;
      beat_addr_q  <= {ADDR_WIDTH{1'b0}};
      beat_idx_q   <= {LEN_WIDTH{1'b0}};
      beat_id_q    <= {ID_WIDTH{1'b0}};
      beat_resp_q  <= AXI_RESP_OKAY;
      len_q        <= {LEN_WIDTH{1'b0}};
      size_q       <= AXI_SIZE_1B;
      burst_q      <= AXI_BURST_FIXED;
      wrap_lower_q <= {ADDR_WIDTH{1'b0}};
      wrap_end_q   <= {ADDR_WIDTH{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_ready_q && cmd_valid) begin
            state_q      <= ST_BURST;
            cmd_ready_q  <= 1'b0;
            beat_valid_q <= 1'b1;
            beat_addr_q  <= cmd_addr;
            beat_idx_q   <= {LEN_WIDTH{1'b0}};
            beat_last_q  <= (cmd_len == {LEN_WIDTH{1'b0}});
            beat_id_q    <= cmd_id;
            beat_resp_q  <= cmd_resp_d;
            len_q        <= cmd_len;
            size_q       <= axi_size_t'(cmd_size);
            burst_q      <= cmd_burst_d;
            wrap_lower_q <= cmd_lower_d;
            wrap_end_q   <= cmd_end_d;
          end else begin
            // Ready rises one cycle after reset release or after a burst ends.
            cmd_ready_q <= 1'b1;
          end
        end
        ST_BURST: begin
          if (beat_ready) begin
            if (beat_last_q) begin
              state_q      <= ST_IDLE;
              beat_valid_q <= 1'b0;
              beat_last_q  <= 1'b0;
            end else begin
              beat_idx_q  <= next_idx_d;
              beat_addr_q <= next_addr_d;
              beat_last_q <= (next_idx_d == len_q);
            end
          end else begin
            // Backpressure: every beat output holds.
            beat_idx_q <= beat_idx_q;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          cmd_ready_q  <= 1'b0;
          beat_valid_q <= 1'b0;
          beat_last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign beat_valid = beat_valid_q;
  assign beat_addr  = beat_addr_q;
  assign beat_idx   = beat_idx_q;
  assign beat_last  = beat_last_q;
  assign beat_id    = beat_id_q;
  assign beat_resp  = beat_resp_q;

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Self-checking bench for axi_burst_addr_gen: directed table, hand-written
// corner sequences and randomized bursts against a behavioural model.
module tb_axi_burst_addr_gen;

  localparam int DW = 32;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic [3:0]  cmd_id;
  logic        beat_valid;
  logic        beat_ready;
  logic [31:0] beat_addr;
  logic [7:0]  beat_idx;
  logic        beat_last;
  logic [3:0]  beat_id;
  logic [1:0]  beat_resp;

  axi_burst_addr_gen #(
    .ADDR_WIDTH(32), .LEN_WIDTH(8), .ID_WIDTH(4), .DATA_WIDTH(DW)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst), .cmd_id(cmd_id),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_addr(beat_addr),
    .beat_idx(beat_idx), .beat_last(beat_last), .beat_id(beat_id), .beat_resp(beat_resp)
  );

  always #5 ACLK = ~ACLK;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_addr [256];
  logic [1:0]  exp_resp;
  logic [31:0] cap_addr [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: beat addresses from the AXI rules using plain arithmetic.
  task automatic model(input logic [31:0] a, input int len, input int size, input int burst);
    longint unsigned av, bytes, total, astart, lower, v;
    bit err;
    av     = {32'd0, a};
    bytes  = 64'd1 << size;
    total  = bytes * longint'(len + 1);
    astart = (av / bytes) * bytes;
    err    = 1'b0;
    if (burst == 3) err = 1'b1;
    if (bytes > longint'(DW / 8)) err = 1'b1;
    if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) err = 1'b1;
    if (burst == 2 && (av % bytes) != 0) err = 1'b1;
    if (burst == 1 && (astart / 4096) != ((astart + total - 1) / 4096)) err = 1'b1;
    exp_resp = err ? 2'b10 : 2'b00;
    lower = (av / total) * total;
    for (int k = 0; k <= len; k++) begin
      if (err || burst == 0) v = av;
      else if (burst == 1) v = (k == 0) ? av : astart + longint'(k) * bytes;
      else v = lower + ((av - lower) + longint'(k) * bytes) % total;
      exp_addr[k] = v[31:0];
    end
  endtask

  // One complete burst with per-beat checks; optional fixed stall or random ready.
  task automatic run_burst(input logic [31:0] a, input int len, input int size, input int burst,
                           input logic [3:0] id, input int stall_idx, input int stall_cycles,
                           input bit rnd_ready);
    int  t;
    int  stalls;
    bit  br;
    model(a, len, size, burst);
    t = 0;
    @(negedge ACLK);
    while (cmd_ready !== 1'b1 && t < 20) begin
      @(negedge ACLK);
      t++;
    end
    if (cmd_ready !== 1'b1) begin
      check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
      return;
    end
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = 8'(len);
    cmd_size = 3'(size); cmd_burst = 2'(burst); cmd_id = id;
    beat_ready = 1'b0;
    @(negedge ACLK);
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_len = 8'($urandom); cmd_id = 4'($urandom);
    check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
    for (int k = 0; k <= len; k++) begin
      stalls = 0;
      for (int c = 0; c < 40; c++) begin
        if (k == stall_idx && stalls < stall_cycles) br = 1'b0;
        else if (rnd_ready && stalls < 4) br = ($urandom_range(0, 3) != 0);
        else br = 1'b1;
        beat_ready = br;
        check($sformatf("valid[%0d]", k), 32'(beat_valid), 32'd1);
        check($sformatf("addr[%0d]", k), beat_addr, exp_addr[k]);
        check($sformatf("idx[%0d]", k), 32'(beat_idx), 32'(k));
        check($sformatf("last[%0d]", k), 32'(beat_last), 32'(k == len));
        check($sformatf("resp[%0d]", k), 32'(beat_resp), 32'(exp_resp));
        check($sformatf("id[%0d]", k), 32'(beat_id), 32'(id));
        cap_addr[k] = beat_addr;
        @(negedge ACLK);
        if (br) break;
        stalls++;
      end
    end
    beat_ready = 1'b0;
    check("idle_valid", 32'(beat_valid), 32'd0);
    check("idle_cmd_ready", 32'(cmd_ready), 32'd0);
    @(negedge ACLK);
    check("cmd_ready_return", 32'(cmd_ready), 32'd1);
  endtask

  typedef struct {
    logic [31:0] addr;
    int          len;
    int          size;
    int          burst;
    logic [1:0]  resp;
    logic [31:0] a0, a1, a2, alast;
  } vec_t;

  vec_t tbl [10];

  initial begin
    tbl[0] = '{32'h1000, 3,   2, 1, 2'b00, 32'h1000, 32'h1004, 32'h1008, 32'h100C};
    tbl[1] = '{32'h0108, 3,   2, 2, 2'b00, 32'h0108, 32'h010C, 32'h0100, 32'h0104};
    tbl[2] = '{32'h2000, 2,   2, 0, 2'b00, 32'h2000, 32'h2000, 32'h2000, 32'h2000};
    tbl[3] = '{32'h1003, 2,   2, 1, 2'b00, 32'h1003, 32'h1004, 32'h1008, 32'h1008};
    tbl[4] = '{32'h0040, 2,   2, 2, 2'b10, 32'h0040, 32'h0040, 32'h0040, 32'h0040};
    tbl[5] = '{32'h0FF8, 3,   2, 1, 2'b10, 32'h0FF8, 32'h0FF8, 32'h0FF8, 32'h0FF8};
    tbl[6] = '{32'h0500, 1,   3, 1, 2'b10, 32'h0500, 32'h0500, 32'h0000, 32'h0500};
    tbl[7] = '{32'h0000, 255, 0, 1, 2'b00, 32'h0000, 32'h0001, 32'h0002, 32'h00FF};
    tbl[8] = '{32'h0700, 0,   2, 1, 2'b00, 32'h0700, 32'h0000, 32'h0000, 32'h0700};
    tbl[9] = '{32'h0080, 1,   2, 3, 2'b10, 32'h0080, 32'h0080, 32'h0000, 32'h0080};

    ARESET = 1'b1; cmd_valid = 1'b0; cmd_addr = 32'h0; cmd_len = 8'h0;
    cmd_size = 3'd0; cmd_burst = 2'd0; cmd_id = 4'h0; beat_ready = 1'b0;

    // Reset values
    repeat (2) @(negedge ACLK);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_valid", 32'(beat_valid), 32'd0);
    check("rst_last", 32'(beat_last), 32'd0);
    check("rst_addr", beat_addr, 32'h0);
    check("rst_idx", 32'(beat_idx), 32'd0);
    check("rst_id", 32'(beat_id), 32'd0);
    check("rst_resp", 32'(beat_resp), 32'd0);
    ARESET = 1'b0;
    #1 check("rel_cmd_ready_low", 32'(cmd_ready), 32'd0);
    @(posedge ACLK); #1;
    check("rel_cmd_ready_high", 32'(cmd_ready), 32'd1);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      run_burst(tbl[i].addr, tbl[i].len, tbl[i].size, tbl[i].burst, 4'(i), -1, 0, 1'b0);
      check($sformatf("tbl%0d_resp", i), 32'(beat_resp), 32'(tbl[i].resp));
      check($sformatf("tbl%0d_a0", i), cap_addr[0], tbl[i].a0);
      if (tbl[i].len >= 1) check($sformatf("tbl%0d_a1", i), cap_addr[1], tbl[i].a1);
      if (tbl[i].len >= 2) check($sformatf("tbl%0d_a2", i), cap_addr[2], tbl[i].a2);
      check($sformatf("tbl%0d_alast", i), cap_addr[tbl[i].len], tbl[i].alast);
    end

    // Backpressure: five stalled cycles on beat 1
    run_burst(32'h1000, 3, 2, 1, 4'hA, 1, 5, 1'b0);
    check("bp_a1", cap_addr[1], 32'h1004);
    check("bp_a3", cap_addr[3], 32'h100C);

    // Reset in the middle of a burst
    model(32'h3000, 3, 2, 1);
    @(negedge ACLK);
    cmd_valid = 1'b1; cmd_addr = 32'h3000; cmd_len = 8'd3;
    cmd_size = 3'd2; cmd_burst = 2'd1; cmd_id = 4'h5;
    @(negedge ACLK);
    cmd_valid = 1'b0; beat_ready = 1'b1;
    check("mid_idx0", 32'(beat_idx), 32'd0);
    @(negedge ACLK);
    beat_ready = 1'b0;
    check("mid_idx1", 32'(beat_idx), 32'd1);
    check("mid_addr1", beat_addr, exp_addr[1]);
    #2 ARESET = 1'b1;
    #1;
    check("mid_rst_valid", 32'(beat_valid), 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("mid_rst_idx", 32'(beat_idx), 32'd0);
    check("mid_rst_addr", beat_addr, 32'h0);
    check("mid_rst_id", 32'(beat_id), 32'd0);
    @(negedge ACLK);
    ARESET = 1'b0;
    check("mid_rel_cmd_ready_low", 32'(cmd_ready), 32'd0);
    @(posedge ACLK); #1;
    check("mid_rel_cmd_ready_high", 32'(cmd_ready), 32'd1);
    run_burst(32'h3100, 1, 2, 1, 4'h6, -1, 0, 1'b0);

    // Randomized bursts against the model
    for (int r = 0; r < 60; r++) begin
      logic [31:0] a;
      int len, size, burst, sel;
      burst = $urandom_range(0, 3);
      size  = $urandom_range(0, 3);
      sel   = $urandom_range(0, 4);
      case (sel)
        0: len = $urandom_range(0, 3);
        1: len = 7;
        2: len = 15;
        3: len = $urandom_range(0, 31);
        default: len = $urandom_range(0, 2);
      endcase
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a = (a & 32'hFFFF_F000) | (32'hF80 + 32'($urandom_range(0, 127)));
      if (burst == 2 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << size) - 32'd1);
      run_burst(a, len, size, burst, 4'($urandom), -1, 0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
